// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the two memory requesters (core, loader), the
// arbiter and the unified memory macro. The slave modport is the arbiter's
// view; the master modport is the environment driving requests and memory
// read data.
interface riscv_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_gnt;
    logic          c_done;

    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_gnt;
    logic          l_done;

    logic [DW-1:0] rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  l_req, l_we, l_addr, l_wdata,
        input  mem_rdata,
        output c_gnt, c_done, l_gnt, l_done,
        output rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output l_req, l_we, l_addr, l_wdata,
        output mem_rdata,
        input  c_gnt, c_done, l_gnt, l_done,
        input  rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Two-requester arbiter for the unified instruction/data memory of the
// multicycle RISC-V core. One access at a time: IDLE picks a winner and
// latches its command, ACCESS holds the memory command for MEM_LAT cycles,
// DONE pulses the owner's done. All outputs are registered.
module riscv_mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MEM_LAT     = 2,
    parameter int PRIO_LOADER = 0
) (
    input  logic                clk,
    input  logic                rst,
    riscv_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_CORE   = 1'b0,
        REQ_LOADER = 1'b1
    } req_id_t;

    localparam int            CW        = (MEM_LAT < 32'sd1) ? 32'sd1 : $clog2(MEM_LAT + 32'sd1);
    localparam logic [CW-1:0] CNT_INIT  = CW'(MEM_LAT - 32'sd1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(32'sd1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(32'sd0);

    state_t        state_r,  state_s;
    req_id_t       owner_r,  owner_s;
    req_id_t       last_r,   last_s;
    logic [CW-1:0] cnt_r,    cnt_s;
    logic          mem_en_r, mem_en_s;
    logic          mem_we_r, mem_we_s;
    logic [AW-1:0] mem_addr_r,  mem_addr_s;
    logic [DW-1:0] mem_wdata_r, mem_wdata_s;
    logic [DW-1:0] rdata_r,  rdata_s;
    logic          c_gnt_r,  c_gnt_s;
    logic          l_gnt_r,  l_gnt_s;
    logic          c_done_r, c_done_s;
    logic          l_done_r, l_done_s;

    req_id_t       win_s;
    logic          tie_s;

    // Pick the requester to serve when both ask at once: fixed loader
    // priority, or alternate away from the last tie winner.
    always_comb begin
        tie_s = bus.c_req & bus.l_req;
        win_s = REQ_CORE;
        if (tie_s) begin
            if (PRIO_LOADER != 32'sd0) begin
                win_s = REQ_LOADER;
            end else if (last_r == REQ_LOADER) begin
                win_s = REQ_CORE;
            end else begin
                win_s = REQ_LOADER;
            end
        end else if (bus.l_req) begin
            win_s = REQ_LOADER;
        end else begin
            win_s = REQ_CORE;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        last_s      = last_r;
        cnt_s       = cnt_r;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        rdata_s     = rdata_r;
        c_gnt_s     = 1'b0;
        l_gnt_s     = 1'b0;
        c_done_s    = 1'b0;
        l_done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.c_req | bus.l_req) begin
                    state_s  = ST_ACCESS;
                    owner_s  = win_s;
                    cnt_s    = CNT_INIT;
                    mem_en_s = 1'b1;
                    // Only a contested grant moves the round-robin pointer.
                    if (tie_s && (PRIO_LOADER == 32'sd0)) begin
                        last_s = win_s;
                    end else begin
                        last_s = last_r;
                    end
                    if (win_s == REQ_LOADER) begin
                        mem_we_s    = bus.l_we;
                        mem_addr_s  = bus.l_addr;
                        mem_wdata_s = bus.l_wdata;
                        l_gnt_s     = 1'b1;
                    end else begin
                        mem_we_s    = bus.c_we;
                        mem_addr_s  = bus.c_addr;
                        mem_wdata_s = bus.c_wdata;
                        c_gnt_s     = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_DONE;
                    // Read data is valid in the last access cycle only.
                    if (!mem_we_r) begin
                        rdata_s = bus.mem_rdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    if (owner_r == REQ_LOADER) begin
                        l_done_s = 1'b1;
                    end else begin
                        c_done_s = 1'b1;
                    end
                end else begin
                    cnt_s    = cnt_r - CNT_ONE;
                    mem_en_s = 1'b1;
                    mem_we_s = mem_we_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears every output at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            owner_r     <= REQ_LOADER;
            last_r      <= REQ_LOADER;
            cnt_r       <= CNT_ZERO;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            rdata_r     <= {DW{1'b0}};
            c_gnt_r     <= 1'b0;
            l_gnt_r     <= 1'b0;
            c_done_r    <= 1'b0;
            l_done_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            last_r      <= last_s;
            cnt_r       <= cnt_s;
            mem_en_r    <= mem_en_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            rdata_r     <= rdata_s;
            c_gnt_r     <= c_gnt_s;
            l_gnt_r     <= l_gnt_s;
            c_done_r    <= c_done_s;
            l_done_r    <= l_done_s;
        end
    end

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.rdata     = rdata_r;
    assign bus.c_gnt     = c_gnt_r;
    assign bus.l_gnt     = l_gnt_r;
    assign bus.c_done    = c_done_r;
    assign bus.l_done    = l_done_r;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: two instances (latency 2 round-robin, and
// latency 1 loader-priority) driven by directed then random requests and
// compared every cycle against a transaction-schedule reference model.
module tb_riscv_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic pl_en;

    always #5 clk = ~clk;

    riscv_mem_arbiter_if #(.AW(32), .DW(32)) b0 ();
    riscv_mem_arbiter_if #(.AW(32), .DW(32)) b1 ();

    riscv_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .PRIO_LOADER(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    riscv_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .PRIO_LOADER(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    // ---------------- memory macros (32 words each) ----------------
    logic [31:0] emem0 [32];
    logic [31:0] emem1 [32];

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // Preload while pl_en, otherwise accept writes from each arbiter.
    always @(posedge clk) begin
        if (pl_en) begin
            for (int i = 0; i < 32; i++) begin
                emem0[i] <= init_word(i);
                emem1[i] <= init_word(i);
            end
        end else begin
            if (b0.mem_en && b0.mem_we) emem0[b0.mem_addr[6:2]] <= b0.mem_wdata;
            if (b1.mem_en && b1.mem_we) emem1[b1.mem_addr[6:2]] <= b1.mem_wdata;
        end
    end

    assign b0.mem_rdata = emem0[b0.mem_addr[6:2]];
    assign b1.mem_rdata = emem1[b1.mem_addr[6:2]];

    // ---------------- checking ----------------
    int errs   = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each accepted transaction is described by its acceptance cycle s:
    // gnt at s+1, memory enabled s+1..s+L, done at s+L+1, idle again at s+L+2.
    int          lat  [2] = '{2, 1};
    bit          prio [2] = '{1'b0, 1'b1};
    bit          tv   [2];
    int          ts   [2];
    bit          town [2];
    bit          twe  [2];
    logic [31:0] taddr[2];
    logic [31:0] twd  [2];
    logic [31:0] trd  [2];
    logic [31:0] rbase[2];
    logic [31:0] saved[2];
    bit          last_ld[2];
    int          free_at[2];
    logic [31:0] mmem [2][32];

    bit          cr [2];
    bit          cw [2];
    bit          lr [2];
    bit          lw [2];
    logic [31:0] ca [2];
    logic [31:0] cwd[2];
    logic [31:0] la [2];
    logic [31:0] lwd[2];

    function automatic logic [31:0] eff_rdata(input int d, input int c);
        if (tv[d] && !twe[d] && ((c - ts[d]) >= lat[d] + 1)) return trd[d];
        return rbase[d];
    endfunction

    task automatic model_reset(input int c);
        for (int d = 0; d < 2; d++) begin
            // A write reset during its first access cycle never reached memory.
            if (tv[d] && twe[d] && ((c - ts[d]) == 1)) mmem[d][taddr[d][6:2]] = saved[d];
            tv[d]      = 1'b0;
            rbase[d]   = 32'h0;
            last_ld[d] = 1'b1;
            free_at[d] = c;
        end
    endtask

    task automatic accept(input int d, input int c);
        bit ld;
        int idx;
        if (c < free_at[d] || !(cr[d] || lr[d])) return;
        if (cr[d] && lr[d]) begin
            if (prio[d]) begin
                ld = 1'b1;
            end else begin
                ld         = !last_ld[d];
                last_ld[d] = ld;
            end
        end else begin
            ld = lr[d];
        end
        rbase[d] = eff_rdata(d, c);
        tv[d]    = 1'b1;
        ts[d]    = c;
        town[d]  = ld;
        twe[d]   = ld ? lw[d]  : cw[d];
        taddr[d] = ld ? la[d]  : ca[d];
        twd[d]   = ld ? lwd[d] : cwd[d];
        idx      = int'(taddr[d][6:2]);
        if (twe[d]) begin
            saved[d]     = mmem[d][idx];
            mmem[d][idx] = twd[d];
        end else begin
            trd[d] = mmem[d][idx];
        end
        free_at[d] = c + lat[d] + 2;
    endtask

    task automatic check_dut(input int d, input int c);
        logic [5:0]  o_fl, e_fl;
        logic [31:0] o_a, o_wd, o_rd;
        int  k;
        bit  g, en, dn;
        if (d == 0) begin
            o_fl = {b0.c_gnt, b0.l_gnt, b0.c_done, b0.l_done, b0.mem_en, b0.mem_we};
            o_a  = b0.mem_addr;  o_wd = b0.mem_wdata; o_rd = b0.rdata;
        end else begin
            o_fl = {b1.c_gnt, b1.l_gnt, b1.c_done, b1.l_done, b1.mem_en, b1.mem_we};
            o_a  = b1.mem_addr;  o_wd = b1.mem_wdata; o_rd = b1.rdata;
        end
        k  = c - ts[d];
        g  = tv[d] && (k == 1);
        en = tv[d] && (k >= 1) && (k <= lat[d]);
        dn = tv[d] && (k == lat[d] + 1);
        e_fl = {g && !town[d], g && town[d], dn && !town[d], dn && town[d], en, en && twe[d]};
        check_eq($sformatf("d%0d.ctl@%0d", d, c),   {26'd0, o_fl}, {26'd0, e_fl});
        check_eq($sformatf("d%0d.addr@%0d", d, c),  o_a,  tv[d] ? taddr[d] : 32'h0);
        check_eq($sformatf("d%0d.wdata@%0d", d, c), o_wd, tv[d] ? twd[d]   : 32'h0);
        check_eq($sformatf("d%0d.rdata@%0d", d, c), o_rd, eff_rdata(d, c));
    endtask

    task automatic apply(input int d);
        if (d == 0) begin
            b0.c_req = cr[0]; b0.c_we = cw[0]; b0.c_addr = ca[0]; b0.c_wdata = cwd[0];
            b0.l_req = lr[0]; b0.l_we = lw[0]; b0.l_addr = la[0]; b0.l_wdata = lwd[0];
        end else begin
            b1.c_req = cr[1]; b1.c_we = cw[1]; b1.c_addr = ca[1]; b1.c_wdata = cwd[1];
            b1.l_req = lr[1]; b1.l_we = lw[1]; b1.l_addr = la[1]; b1.l_wdata = lwd[1];
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [4:0] w;
        w = 5'($urandom_range(0, 31));
        return {25'd0, w, 2'b00};
    endfunction

    // Directed prologue, then independent random traffic per instance.
    task automatic stim(input int d, input int c);
        cr[d] = 1'b0; cw[d] = 1'b0; ca[d] = 32'h0; cwd[d] = 32'h0;
        lr[d] = 1'b0; lw[d] = 1'b0; la[d] = 32'h0; lwd[d] = 32'h0;
        if (c >= 60) begin
            cr[d]  = ($urandom_range(0, 99) < 55);
            cw[d]  = 1'($urandom_range(0, 1));
            ca[d]  = rnd_addr();
            cwd[d] = $urandom;
            lr[d]  = ($urandom_range(0, 99) < 55);
            lw[d]  = 1'($urandom_range(0, 1));
            la[d]  = rnd_addr();
            lwd[d] = $urandom;
        end else if (c == 0) begin
            cr[d] = 1'b1; ca[d] = 32'h10;
        end else if (c == 6) begin
            lr[d] = 1'b1; lw[d] = 1'b1; la[d] = 32'h40; lwd[d] = 32'h1234_5678;
        end else if (c >= 12 && c <= 29) begin
            cr[d] = 1'b1; ca[d] = 32'h10;
            lr[d] = 1'b1; la[d] = 32'h40;
        end else if (c >= 34 && c <= 36) begin
            cr[d] = 1'b1; cw[d] = 1'b1; ca[d] = 32'h20; cwd[d] = 32'hCAFE_F00D;
        end else if (c >= 37 && c <= 45) begin
            cr[d] = 1'b1; ca[d] = 32'h14;
            lr[d] = 1'b1; la[d] = 32'h18;
        end else begin
            cr[d] = 1'b0;
        end
        apply(d);
    endtask

    initial begin
        bit in_rst;
        rst   = 1'b0;
        pl_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) mmem[d][i] = init_word(i);
            ts[d] = 0; town[d] = 1'b0; twe[d] = 1'b0;
            taddr[d] = 32'h0; twd[d] = 32'h0; trd[d] = 32'h0; saved[d] = 32'h0;
        end
        model_reset(0);
        for (int d = 0; d < 2; d++) stim(d, -1);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) check_dut(d, -1);
        pl_en = 1'b0;
        rst   = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) check_dut(d, c);
            in_rst = 1'b0;
            if (rst == 1'b0) begin
                rst = 1'b1;
            end else if (c == 36 || (c > 60 && $urandom_range(0, 199) == 0)) begin
                rst = 1'b0;
                #1;
                model_reset(c);
                for (int d = 0; d < 2; d++) check_dut(d, c);
                in_rst = 1'b1;
            end
            for (int d = 0; d < 2; d++) stim(d, c);
            if (!in_rst) begin
                for (int d = 0; d < 2; d++) accept(d, c);
            end
        end

        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            check_eq($sformatf("mem0[%0d]", i), emem0[i], mmem[0][i]);
            check_eq($sformatf("mem1[%0d]", i), emem1[i], mmem[1][i]);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
